// File: rtl/mul_pkg.sv
// mul_pkg: op encodings, FSM states and operand helpers for the 32x32 sequencer
package mul_pkg;
  typedef enum logic [1:0] {
    OP_MUL    = 2'd0,
    OP_MULH   = 2'd1,
    OP_MULHSU = 2'd2,
    OP_MULHU  = 2'd3
  } op_e;
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;
  localparam int MULT_LAT_DEF = 1;
  // half-word to 18-bit multiplier operand, sign-extended only when s is set
  function automatic logic [17:0] ext18(input logic [15:0] h, input logic s);
    return {{2{s & h[15]}}, h};
  endfunction
  // partial-product weight in 16-bit units from the issue index: LL=0, LH=1, HL=1, HH=2
  function automatic logic [1:0] shift_of(input logic [1:0] idx);
    return {1'b0, idx[1]} + {1'b0, idx[0]};
  endfunction
endpackage

// File: rtl/mul32_acc.sv
// mul32_acc: tag pipe matching multiplier latency plus 64-bit sign-extend, shift and accumulate
module mul32_acc
  import mul_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        add,
  input  logic [1:0]  shift,
  input  logic [35:0] mul_p,
  output logic [63:0] sum,
  output logic        drained
);
  localparam logic [MULT_LAT-1:0] LAST = MULT_LAT'(1) << (MULT_LAT - 1);
  logic [MULT_LAT-1:0] tv;
  logic [1:0]          ts [MULT_LAT];
  logic [63:0]         acc;
  logic [63:0]         term;
  // the product on mul_p belongs to the tag at the pipe tail; drained means nothing else is in flight
  always_comb begin
    term    = {{28{mul_p[35]}}, mul_p} << {ts[MULT_LAT-1], 4'd0};
    sum     = tv[MULT_LAT-1] ? acc + term : acc;
    drained = !add && (tv & ~LAST) == '0;
  end
  // tags advance one stage per cycle alongside the multiplier; clear drops tags and zeroes the sum
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tv  <= '0;
      acc <= '0;
      for (int i = 0; i < MULT_LAT; i++) ts[i] <= '0;
    end else if (clear) begin
      tv  <= '0;
      acc <= '0;
    end else begin
      tv[0] <= add;
      ts[0] <= shift;
      for (int i = 1; i < MULT_LAT; i++) begin
        tv[i] <= tv[i-1];
        ts[i] <= ts[i-1];
      end
      acc <= sum;
    end
  end
endmodule

// File: rtl/mul32_seq.sv
// mul32_seq: 32x32 multiply sequencer driving one shared 18x18 signed DSP
module mul32_seq
  import mul_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic        kill,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        busy,
  output logic [17:0] mul_a,
  output logic [17:0] mul_b,
  output logic        mul_en,
  input  logic [35:0] mul_p
);
  state_e      state;
  op_e         op;
  logic [31:0] a, b;
  logic [1:0]  idx, nidx;
  logic        sa, sb, last, clear, issuing, drained;
  logic [17:0] na, nb;
  logic [63:0] sum;
  // operands for the next partial product: idx[1] picks A high, idx[0] picks B high
  always_comb begin
    sa      = op == OP_MULH || op == OP_MULHSU;
    sb      = op == OP_MULH;
    nidx    = idx + 2'd1;
    na      = nidx[1] ? ext18(a[31:16], sa) : {2'b0, a[15:0]};
    nb      = nidx[0] ? ext18(b[31:16], sb) : {2'b0, b[15:0]};
    last    = idx == (op == OP_MUL ? 2'd2 : 2'd3);
    issuing = state == S_ISSUE;
    clear   = state == S_IDLE ? req_valid : kill;
  end
  mul32_acc #(.MULT_LAT(MULT_LAT)) u_acc (
    .clk    (clk),
    .rst    (rst),
    .clear  (clear),
    .add    (issuing),
    .shift  (shift_of(idx)),
    .mul_p  (mul_p),
    .sum    (sum),
    .drained(drained)
  );
  // control FSM with registered handshake and multiplier outputs; kill outranks everything but reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      op         <= OP_MUL;
      a          <= '0;
      b          <= '0;
      idx        <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      busy       <= 1'b0;
      mul_en     <= 1'b0;
      mul_a      <= '0;
      mul_b      <= '0;
    end else if (state != S_IDLE && kill) begin
      state      <= S_IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      busy       <= 1'b0;
      mul_en     <= 1'b0;
      mul_a      <= '0;
      mul_b      <= '0;
    end else begin
      case (state)
        S_IDLE: if (req_valid) begin
          state     <= S_ISSUE;
          op        <= op_e'(req_op);
          a         <= req_a;
          b         <= req_b;
          idx       <= '0;
          req_ready <= 1'b0;
          busy      <= 1'b1;
          mul_en    <= 1'b1;
          mul_a     <= {2'b0, req_a[15:0]};
          mul_b     <= {2'b0, req_b[15:0]};
        end
        S_ISSUE: if (last) begin
          state <= S_DRAIN;
          mul_a <= '0;
          mul_b <= '0;
        end else begin
          idx   <= nidx;
          mul_a <= na;
          mul_b <= nb;
        end
        S_DRAIN: if (drained) begin
          state      <= S_DONE;
          resp_valid <= 1'b1;
          mul_en     <= 1'b0;
          resp_data  <= op == OP_MUL ? sum[31:0] : sum[63:32];
        end
        default: if (resp_ready) begin
          state      <= S_IDLE;
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
          busy       <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mul32_seq.sv
// tb_mul32_seq: checks mul32_seq at MULT_LAT 1, 2 and 3 against a 64-bit arithmetic reference
module tb_mul32_seq;
  localparam int N = 3;
  logic        clk = 1'b0, rst = 1'b0;
  logic        req_valid = 1'b0, kill = 1'b0, resp_ready = 1'b1;
  logic [1:0]  req_op = 2'd0;
  logic [31:0] req_a = '0, req_b = '0;
  logic        req_ready [N];
  logic        resp_valid [N];
  logic        busy [N];
  logic        mul_en [N];
  logic [31:0] resp_data [N];
  logic [17:0] mul_a [N];
  logic [17:0] mul_b [N];
  logic [35:0] mul_p [N];
  logic        seen [N];
  int          seen_cyc [N];
  logic [31:0] seen_data [N];
  int          cyc = 0, compared = 0, mismatched = 0, t_acc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < N; g++) begin : gen_dut
    logic [35:0] pp [g+1];
    mul32_seq #(.MULT_LAT(g + 1)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready[g]), .req_op(req_op),
      .req_a(req_a), .req_b(req_b), .kill(kill), .resp_valid(resp_valid[g]), .resp_ready(resp_ready),
      .resp_data(resp_data[g]), .busy(busy[g]), .mul_a(mul_a[g]), .mul_b(mul_b[g]),
      .mul_en(mul_en[g]), .mul_p(mul_p[g])
    );
    always @(posedge clk) if (mul_en[g]) begin
      pp[0] <= $signed({{18{mul_a[g][17]}}, mul_a[g]}) * $signed({{18{mul_b[g][17]}}, mul_b[g]});
      for (int i = 1; i <= g; i++) pp[i] <= pp[i-1];
    end
    assign mul_p[g] = pp[g];
  end

  always @(negedge clk)
    for (int k = 0; k < N; k++)
      if (resp_valid[k] && !seen[k]) begin
        seen[k] = 1'b1;
        seen_cyc[k] = cyc;
        seen_data[k] = resp_data[k];
      end

  function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = (op == 2'd1 || op == 2'd2) ? {{32{a[31]}}, a} : {32'd0, a};
    eb = (op == 2'd1) ? {{32{b[31]}}, b} : {32'd0, b};
    p = ea * eb;
    return op == 2'd0 ? p[31:0] : p[63:32];
  endfunction

  task automatic clear_seen();
    for (int j = 0; j < N; j++) seen[j] = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    for (int j = 0; j < N; j++) begin
      compared++;
      if (req_ready[j] !== 1'b1 || resp_valid[j] !== 1'b0 || resp_data[j] !== 32'd0 || busy[j] !== 1'b0 ||
          mul_en[j] !== 1'b0 || mul_a[j] !== 18'd0 || mul_b[j] !== 18'd0) begin
        mismatched++;
        $display("FAIL %s lat=%0d: rdy=%b vld=%b data=%h busy=%b en=%b a=%h b=%h, required 1 0 0 0 0 0 0",
                 tag, j + 1, req_ready[j], resp_valid[j], resp_data[j], busy[j], mul_en[j], mul_a[j], mul_b[j]);
      end
    end
  endtask

  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic k);
    logic [31:0] exp;
    exp = ref_mul(op, a, b);
    clear_seen();
    @(negedge clk);
    for (int j = 0; j < N; j++) begin
      compared++;
      if (req_ready[j] !== 1'b1) begin
        mismatched++;
        $display("FAIL idle_ready lat=%0d: got %b, required 1", j + 1, req_ready[j]);
      end
    end
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; kill = k;
    @(negedge clk);
    t_acc = cyc; req_valid = 1'b0; kill = 1'b0;
    for (int j = 0; j < N; j++) begin
      compared++;
      if (busy[j] !== 1'b1) begin
        mismatched++;
        $display("FAIL accept_busy lat=%0d: got %b, required 1", j + 1, busy[j]);
      end
    end
    repeat (12) @(negedge clk);
    for (int j = 0; j < N; j++) begin
      compared += 2;
      if (!seen[j] || seen_data[j] !== exp) begin
        mismatched++;
        $display("FAIL result op=%0d a=%h b=%h lat=%0d: seen=%b got %h, required %h", op, a, b, j + 1, seen[j], seen_data[j], exp);
      end
      if (!seen[j] || seen_cyc[j] - t_acc != (op == 2'd0 ? 3 : 4) + j + 1) begin
        mismatched++;
        $display("FAIL latency op=%0d lat=%0d: got %0d, required %0d", op, j + 1, seen_cyc[j] - t_acc, (op == 2'd0 ? 3 : 4) + j + 1);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [1:0]  ops [8] = '{2'd0, 2'd3, 2'd1, 2'd3, 2'd2, 2'd1, 2'd0, 2'd2};
    logic [31:0] as  [8] = '{32'h00010003, 32'h00010003, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};
    logic [31:0] bs  [8] = '{32'h00020005, 32'h00020005, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF};
    for (int i = 0; i < 8; i++) do_op(ops[i], as[i], bs[i], 1'b0);
  endtask

  task automatic test_random();
    logic [31:0] v [2];
    for (int i = 0; i < 24; i++) begin
      for (int s = 0; s < 2; s++)
        case ($urandom_range(0, 4))
          0: v[s] = 32'h0;
          1: v[s] = 32'hFFFFFFFF;
          2: v[s] = 32'h80000000;
          3: v[s] = 32'h7FFFFFFF;
          default: v[s] = $urandom;
        endcase
      do_op(2'($urandom_range(0, 3)), v[0], v[1], $urandom_range(0, 3) == 0);
    end
  endtask

  task automatic test_stall();
    logic [31:0] a, b, exp;
    a = $urandom; b = $urandom; exp = ref_mul(2'd1, a, b);
    resp_ready = 1'b0;
    clear_seen();
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'd1; req_a = a; req_b = b;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (8) @(negedge clk);
    repeat (5) begin
      for (int j = 0; j < N; j++) begin
        compared++;
        if (resp_valid[j] !== 1'b1 || resp_data[j] !== exp || req_ready[j] !== 1'b0 || busy[j] !== 1'b1) begin
          mismatched++;
          $display("FAIL stall_hold lat=%0d: vld=%b data=%h rdy=%b busy=%b, required 1 %h 0 1",
                   j + 1, resp_valid[j], resp_data[j], req_ready[j], busy[j], exp);
        end
      end
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    for (int j = 0; j < N; j++) begin
      compared++;
      if (resp_valid[j] !== 1'b0 || req_ready[j] !== 1'b1 || busy[j] !== 1'b0) begin
        mismatched++;
        $display("FAIL stall_release lat=%0d: vld=%b rdy=%b busy=%b, required 0 1 0", j + 1, resp_valid[j], req_ready[j], busy[j]);
      end
    end
    clear_seen();
    req_valid = 1'b1; req_op = 2'd0; req_a = b; req_b = a;
    @(negedge clk);
    req_valid = 1'b0;
    for (int j = 0; j < N; j++) begin
      compared++;
      if (busy[j] !== 1'b1) begin
        mismatched++;
        $display("FAIL stall_next_accept lat=%0d: busy=%b, required 1", j + 1, busy[j]);
      end
    end
    repeat (12) @(negedge clk);
    for (int j = 0; j < N; j++) begin
      compared++;
      if (!seen[j] || seen_data[j] !== ref_mul(2'd0, b, a)) begin
        mismatched++;
        $display("FAIL stall_next_result lat=%0d: seen=%b got %h, required %h", j + 1, seen[j], seen_data[j], ref_mul(2'd0, b, a));
      end
    end
  endtask

  task automatic test_kill();
    clear_seen();
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'd1; req_a = $urandom; req_b = $urandom;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    for (int j = 0; j < N; j++) begin
      compared++;
      if (busy[j] !== 1'b0 || resp_valid[j] !== 1'b0 || req_ready[j] !== 1'b1) begin
        mismatched++;
        $display("FAIL kill_idle lat=%0d: busy=%b vld=%b rdy=%b, required 0 0 1", j + 1, busy[j], resp_valid[j], req_ready[j]);
      end
    end
    repeat (10) @(negedge clk);
    for (int j = 0; j < N; j++) begin
      compared++;
      if (seen[j] !== 1'b0) begin
        mismatched++;
        $display("FAIL kill_no_resp lat=%0d: seen=%b, required 0", j + 1, seen[j]);
      end
    end
    do_op(2'd3, 32'd3, 32'd5, 1'b0);
    do_op(2'd0, 32'd3, 32'd5, 1'b0);
  endtask

  task automatic test_async_rst();
    for (int r = 0; r < 2; r++) begin
      clear_seen();
      @(negedge clk);
      req_valid = 1'b1; req_op = 2'd1; req_a = $urandom; req_b = $urandom;
      @(negedge clk);
      req_valid = 1'b0;
      repeat (4) @(negedge clk);
      for (int j = 0; j < N; j++) begin
        compared++;
        if (busy[j] !== 1'b1 || mul_en[j] !== 1'b1 || resp_valid[j] !== 1'b0) begin
          mismatched++;
          $display("FAIL drain_state lat=%0d: busy=%b en=%b vld=%b, required 1 1 0", j + 1, busy[j], mul_en[j], resp_valid[j]);
        end
      end
      #1 rst = 1'b1;
      #1 check_reset_values("async_rst");
      #1 rst = 1'b0;
      repeat (10) @(negedge clk);
      for (int j = 0; j < N; j++) begin
        compared++;
        if (seen[j] !== 1'b0) begin
          mismatched++;
          $display("FAIL rst_no_resp lat=%0d: seen=%b, required 0", j + 1, seen[j]);
        end
      end
      do_op(2'($urandom_range(0, 3)), $urandom, $urandom, 1'b0);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_directed();
    test_random();
    test_stall();
    test_kill();
    test_async_rst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
